line_buf_ctrl: RTL and testbench

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

---
 rtl/line_buf_pkg.sv | 22 ++
 rtl/line_buf_ctrl.sv | 166 ++++++++++++++++
 tb/tb_line_buf_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/line_buf_pkg.sv
// Shared types and default geometry for the line-buffer controller.
package line_buf_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam int DEF_INPUT_SIZE   = 8;
  localparam int DEF_LINE_WIDTH   = 114;
  localparam int DEF_FRAME_HEIGHT = 114;
  localparam int DEF_KERNEL       = 4;
  localparam int WIN_COORD_W      = 7;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_buf_ctrl.sv
// Sequences a line buffer through clear, pixel streaming and window-ready
// strobes for one frame; the buffer itself lives in the parent.
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int INPUT_SIZE   = DEF_INPUT_SIZE,
  parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int KERNEL       = DEF_KERNEL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [INPUT_SIZE-1:0]  in_data,
  output logic                   in_ready,
  output logic                   buf_rst,
  output logic                   buf_en,
  output logic [INPUT_SIZE-1:0]  buf_wdata,
  output logic                   win_valid,
  output logic [WIN_COORD_W-1:0] win_row,
  output logic [WIN_COORD_W-1:0] win_col,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_underrun,
  output state_e                 dbg_state
);

  localparam int CW = cnt_width(LINE_WIDTH);
  localparam int RW = cnt_width(FRAME_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic [CW-1:0] COL_K    = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(KERNEL - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          clr_q, clr_d;
  logic                   started_q, started_d;
  logic                   err_q, err_d;
  logic                   win_valid_q, win_valid_d;
  logic [WIN_COORD_W-1:0] win_row_q, win_row_d;
  logic [WIN_COORD_W-1:0] win_col_q, win_col_d;

  // Handshake: a pixel moves when in_valid && in_ready; in_ready is high only
  // in RUN. Once the first pixel moves, in_valid must stay high until the
  // frame's last pixel, otherwise the controller latches an underrun.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    clr_d       = clr_q;
    started_d   = started_q;
    err_d       = err_q;
    win_valid_d = 1'b0;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    in_ready    = 1'b0;
    buf_en      = 1'b0;
    buf_rst     = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      IDLE: begin
        buf_rst = 1'b1;
        if (start) begin
          state_d   = CLEAR;
          col_d     = '0;
          row_d     = '0;
          clr_d     = '0;
          started_d = 1'b0;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (clr_q == COL_LAST) begin
          clr_d   = '0;
          state_d = RUN;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        buf_en   = in_valid;
        if (in_valid) begin
          started_d = 1'b1;
          if ((row_q >= ROW_K) && (col_q >= COL_K)) begin
            win_valid_d = 1'b1;
            win_row_d   = WIN_COORD_W'(row_q);
            win_col_d   = WIN_COORD_W'(col_q);
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end else if (started_q) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          // Waiting for the first pixel: hold the buffer so it cannot advance.
          buf_rst = 1'b1;
        end
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        buf_rst = 1'b1;
        if (start) begin
          err_d     = 1'b0;
          state_d   = CLEAR;
          col_d     = '0;
          row_d     = '0;
          clr_d     = '0;
          started_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      clr_q       <= '0;
      started_q   <= 1'b0;
      err_q       <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      clr_q       <= clr_d;
      started_q   <= started_d;
      err_q       <= err_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  assign buf_wdata    = in_data;
  assign win_valid    = win_valid_q;
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;
  assign err_underrun = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl: vector tables for idle/clear/run entry,
// full-frame window scoreboard, underrun and mid-frame reset sequences.
module tb_line_buf_ctrl;
  import line_buf_pkg::*;

  localparam int LW     = 114;
  localparam int FH     = 114;
  localparam int K      = 4;
  localparam int N_WIN  = (LW - K + 1) * (FH - K + 1);
  localparam int N_PIX  = LW * FH;

  logic       clk, rst, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, buf_rst, buf_en, win_valid, busy, frame_done, err_underrun;
  logic [7:0] buf_wdata;
  logic [6:0] win_row, win_col;
  state_e     dbg_state;

  line_buf_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .buf_rst(buf_rst), .buf_en(buf_en), .buf_wdata(buf_wdata),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .busy(busy),
    .frame_done(frame_done), .err_underrun(err_underrun), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  int win_cnt = 0;
  logic [13:0] first_rc = '0;
  int pr = 0;
  int pc = 0;

  typedef struct {
    logic   start;
    logic   vld;
    logic [7:0] data;
    logic   e_rdy;
    logic   e_en;
    logic   e_brst;
    logic   e_busy;
    state_e e_st;
  } vec_t;

  vec_t tab1[5];
  vec_t tab2[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard: one expected {row,col} per window pulse
  always @(negedge clk) begin
    if (win_valid) begin
      if (exp_q.size() == 0) begin
        chk("win_unexpected", {18'd0, win_row, win_col}, 32'hFFFF_FFFF);
      end else begin
        chk("win_coord", {18'd0, win_row, win_col}, {18'd0, exp_q.pop_front()});
      end
      if (win_cnt == 0) first_rc = {win_row, win_col};
      win_cnt++;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err"}, err_underrun, 0);
    chk({tag, "_buf_rst"}, buf_rst, 1);
    chk({tag, "_buf_en"}, buf_en, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_col"}, win_col, 0);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    start = v.start; in_valid = v.vld; in_data = v.data;
    #1;
    chk({tag, "_in_ready"}, in_ready, v.e_rdy);
    chk({tag, "_buf_en"}, buf_en, v.e_en);
    chk({tag, "_buf_rst"}, buf_rst, v.e_brst);
    chk({tag, "_busy"}, busy, v.e_busy);
    chk({tag, "_state"}, 32'(dbg_state), 32'(v.e_st));
    chk({tag, "_wdata"}, buf_wdata, v.data);
  endtask

  // Counts CLEAR cycles from the next negedge; returns on the first RUN cycle.
  task automatic clear_wait(input int init);
    int n = init;
    int guard = 0;
    forever begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      #1;
      if (dbg_state != CLEAR || guard > 300) break;
      if (buf_en !== 1'b0 || buf_rst !== 1'b0 || in_ready !== 1'b0)
        chk("clear_outputs", {buf_en, buf_rst, in_ready}, 3'b000);
      n++; guard++;
    end
    chk("clear_len", n, LW);
    chk("run_state", 32'(dbg_state), 32'(RUN));
    chk("run_in_ready", in_ready, 1);
    chk("run_wait_buf_rst", buf_rst, 1);
    chk("run_wait_buf_en", buf_en, 0);
  endtask

  task automatic start_and_clear();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    clear_wait(0);
  endtask

  task automatic feed(input int n, input bit poke);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      start    = poke && ($urandom_range(0, 31) == 0);
      #1;
      chk("pix_buf_en", buf_en, 1);
      chk("pix_wdata", buf_wdata, in_data);
      chk("pix_buf_rst", buf_rst, 0);
      if (pr >= K - 1 && pc >= K - 1) exp_q.push_back({7'(pr), 7'(pc)});
      pc++;
      if (pc == LW) begin pc = 0; pr++; end
    end
  endtask

  task automatic frame_end();
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    #1;
    chk("end_frame_done", frame_done, 1);
    chk("end_state_done", 32'(dbg_state), 32'(DONE));
    chk("end_busy", busy, 1);
    chk("end_in_ready", in_ready, 0);
    @(negedge clk);
    #1;
    chk("post_frame_done", frame_done, 0);
    chk("post_state", 32'(dbg_state), 32'(IDLE));
    chk("post_busy", busy, 0);
    chk("post_buf_rst", buf_rst, 1);
    chk("win_count", win_cnt, N_WIN);
    chk("win_first", {18'd0, first_rc}, {18'd0, 7'd3, 7'd3});
    chk("exp_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tab1[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, IDLE};
    tab1[1] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, IDLE};
    tab1[2] = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, IDLE};
    tab1[3] = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, CLEAR};
    tab1[4] = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, CLEAR};
    tab2[0] = '{1'b0, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, RUN};
    tab2[1] = '{1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b1, 1'b1, RUN};

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #22;
    check_reset("rst0");
    @(negedge clk);
    rst = 1'b1;

    // Frame 1: table-driven idle/clear/run entry, then a full frame with stray starts
    for (int i = 0; i < 5; i++) apply_vec(tab1[i], $sformatf("t1_%0d", i));
    clear_wait(2);
    for (int i = 0; i < 2; i++) apply_vec(tab2[i], $sformatf("t2_%0d", i));
    win_cnt = 0; pr = 0; pc = 0;
    feed(N_PIX, 1'b1);
    frame_end();

    // Underrun at row 5 col 20
    pr = 0; pc = 0;
    start_and_clear();
    feed(5 * LW + 20, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("drop_state_run", 32'(dbg_state), 32'(RUN));
    chk("drop_buf_en", buf_en, 0);
    chk("drop_buf_rst", buf_rst, 0);
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("err_state", 32'(dbg_state), 32'(ERR));
    chk("err_flag", err_underrun, 1);
    chk("err_buf_en", buf_en, 0);
    chk("err_in_ready", in_ready, 0);
    chk("err_buf_rst", buf_rst, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("err_sticky", err_underrun, 1);
    chk("err_q_empty", exp_q.size(), 0);
    start_and_clear();
    chk("err_cleared", err_underrun, 0);

    // Mid-frame reset at row 50, then a full clean frame
    pr = 0; pc = 0;
    feed(50 * LW + 10, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset("rst_mid");
    exp_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    win_cnt = 0; pr = 0; pc = 0;
    start_and_clear();
    feed(N_PIX, 1'b0);
    frame_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
